// File: rtl/ds_frame_arbiter.sv
// Frame-granular round-robin arbiter that merges two camera streams into one downsampler input.
// Optional GRANT watchdog with timeout_err port: define DS_ARB_TIMEOUT_EN.
module ds_frame_arbiter #(
  parameter int unsigned in_width       = 240,
  parameter int unsigned in_height      = 480,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_src,
  output logic       ds_clear,
  output logic       frame_done
`ifdef DS_ARB_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  localparam int unsigned PIXELS = in_width * in_height;
  localparam int unsigned CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic             sel_valid;
  logic [7:0]       sel_data;

`ifdef DS_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(timeout_cycles + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cycles - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  assign m_src     = src_q;
  assign sel_valid = src_q ? s1_valid : s0_valid;
  assign sel_data  = src_q ? s1_data : s0_data;

  // Outputs are gated by reset so an abandoned frame never leaks a transfer or pulse.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    last_d     = last_q;
    m_data     = '0;
    m_valid    = 1'b0;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    ds_clear   = 1'b0;
    frame_done = 1'b0;
`ifdef DS_ARB_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_err = 1'b0;
`endif
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            src_d   = (s0_valid && s1_valid) ? ~last_q : s1_valid;
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          ds_clear = 1'b1;
          cnt_d    = '0;
          state_d  = GRANT;
`ifdef DS_ARB_TIMEOUT_EN
          wd_d = '0;
`endif
        end
        GRANT: begin
          m_data   = sel_data;
          m_valid  = sel_valid;
          s0_ready = ~src_q & m_ready;
          s1_ready = src_q & m_ready;
          if (sel_valid && m_ready) begin
            if (cnt_q == LAST_PIX) begin
              frame_done = 1'b1;
              cnt_d      = '0;
              last_d     = src_q;
              state_d    = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef DS_ARB_TIMEOUT_EN
          if (sel_valid) begin
            wd_d = '0;
          end else if (wd_q == WD_LAST) begin
            timeout_err = 1'b1;
            wd_d        = '0;
            cnt_d       = '0;
            last_d      = src_q;
            state_d     = IDLE;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
`ifdef DS_ARB_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      last_q  <= last_d;
`ifdef DS_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_ds_frame_arbiter.sv
// Directed + randomized bench for ds_frame_arbiter against a frame-level arbitration model.
module tb_ds_frame_arbiter;
  localparam int unsigned W = 4;
  localparam int unsigned H = 2;
  localparam int N = W * H;
`ifdef DS_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       s0_ready, s1_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_src, ds_clear, frame_done;
`ifdef DS_ARB_TIMEOUT_EN
  logic       timeout_err;
`endif

  always #5 clk = ~clk;

  ds_frame_arbiter #(
    .in_width(W),
    .in_height(H),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s0_data(s0_data),
    .s0_valid(s0_valid),
    .s0_ready(s0_ready),
    .s1_data(s1_data),
    .s1_valid(s1_valid),
    .s1_ready(s1_ready),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_src(m_src),
    .ds_clear(ds_clear),
    .frame_done(frame_done)
`ifdef DS_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  // Reference model: who owns the output, whether the clear cycle is still due,
  // pixels delivered this frame, last served stream, and each stream's pending pixel.
  int         tests = 0, fails = 0;
  int         owner, sent, last_s, idle_run;
  bit         clear_due, src_m;
  bit         v[2];
  bit         rdy;
  logic [7:0] head[2];
  int         done_cnt, xfer, to_at;
  bit         to_seen;
  int         clr_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit clr, mv, r0, r1, done_e, to_e;
    s0_valid = v[0];
    s1_valid = v[1];
    s0_data  = head[0];
    s1_data  = head[1];
    m_ready  = rdy;
    @(negedge clk);
    clr = 0; mv = 0; r0 = 0; r1 = 0; done_e = 0; to_e = 0;
    if (!reset && owner >= 0) begin
      if (clear_due) clr = 1;
      else begin
        mv     = v[owner];
        r0     = (owner == 0) && rdy;
        r1     = (owner == 1) && rdy;
        done_e = mv && rdy && (sent == N - 1);
        to_e   = !mv && (idle_run == TO - 1);
      end
    end
    chk("ds_clear", ds_clear, clr);
    chk("m_valid", m_valid, mv);
    chk("s0_ready", s0_ready, r0);
    chk("s1_ready", s1_ready, r1);
    chk("frame_done", frame_done, done_e);
`ifdef DS_ARB_TIMEOUT_EN
    chk("timeout_err", timeout_err, to_e);
    if (timeout_err) to_seen = 1;
`else
    to_e = 0;
`endif
    if (!reset) chk("m_src", m_src, src_m);
    if (mv) chk("m_data", m_data, head[owner]);
    if (frame_done) done_cnt++;
    if (m_valid && m_ready) xfer++;
    if (ds_clear) clr_log.push_back(int'(m_src));

    if (reset) begin
      owner = -1; clear_due = 0; sent = 0; last_s = 1; src_m = 0; idle_run = 0;
    end else if (owner < 0) begin
      if (v[0] || v[1]) begin
        owner     = (v[0] && v[1]) ? 1 - last_s : (v[1] ? 1 : 0);
        src_m     = owner[0];
        clear_due = 1;
      end
    end else if (clear_due) begin
      clear_due = 0; sent = 0; idle_run = 0;
    end else if (mv) begin
      idle_run = 0;
      if (rdy) begin
        head[owner] = 8'($urandom);
        sent++;
        if (sent == N) begin
          last_s = owner; owner = -1; sent = 0;
        end
      end
    end else if (to_e) begin
      last_s = owner; owner = -1; sent = 0; idle_run = 0;
    end else begin
      idle_run++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    head[0] = 8'($urandom);
    head[1] = 8'($urandom);
    v[0] = 0; v[1] = 0; rdy = 1;
    owner = -1; sent = 0; last_s = 1; idle_run = 0; clear_due = 0; src_m = 0;
    @(posedge clk);
    #1;
    reset = 1;
    repeat (2) cycle();
    reset = 0;

    // Lone s0 frame with m_ready held high
    v[0] = 1; done_cnt = 0; clr_log.delete();
    repeat (10) cycle();
    v[0] = 0;
    cycle();
    chk("s0_done_count", done_cnt, 1);
    chk("s0_clear_count", clr_log.size(), 1);
    if (clr_log.size() > 0) chk("s0_clear_src", clr_log[0], 0);

    // Both streams valid from reset: s0, s1, s0
    reset = 1; cycle(); reset = 0;
    v[0] = 1; v[1] = 1; done_cnt = 0; clr_log.delete();
    repeat (30) cycle();
    v[0] = 0; v[1] = 0;
    cycle();
    chk("rr_done_count", done_cnt, 3);
    chk("rr_clear_count", clr_log.size(), 3);
    if (clr_log.size() == 3) begin
      chk("rr_src0", clr_log[0], 0);
      chk("rr_src1", clr_log[1], 1);
      chk("rr_src2", clr_log[2], 0);
    end

    // m_ready toggling every cycle
    v[0] = 1; done_cnt = 0; xfer = 0;
    for (int i = 0; i < 60; i++) begin
      rdy = i[0];
      cycle();
      if (done_cnt != 0) break;
    end
    v[0] = 0; rdy = 1;
    cycle();
    chk("toggle_done_count", done_cnt, 1);
    chk("toggle_xfer_count", xfer, N);

    // Reset after 3 pixels abandons the frame
    v[0] = 1; xfer = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (xfer >= 3) break;
    end
    chk("pre_reset_xfer", xfer, 3);
    reset = 1; cycle(); reset = 0;
    chk("no_done_on_reset", done_cnt, 0);
    xfer = 0; clr_log.delete();
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (done_cnt != 0) break;
    end
    v[0] = 0;
    cycle();
    chk("post_reset_done", done_cnt, 1);
    chk("post_reset_xfer", xfer, N);
    chk("post_reset_clear", clr_log.size(), 1);

    // Randomized traffic and backpressure
    reset = 1; cycle(); reset = 0;
    for (int i = 0; i < 500; i++) begin
      v[0] = ($urandom_range(0, 3) != 0);
      v[1] = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    v[0] = 0; v[1] = 0; rdy = 1;

`ifdef DS_ARB_TIMEOUT_EN
    // s1 stalls after 5 pixels; watchdog aborts and s0 gets the next grant
    reset = 1; cycle(); reset = 0;
    v[1] = 1; xfer = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (xfer >= 5) break;
    end
    v[1] = 0; v[0] = 1; to_seen = 0; to_at = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (to_seen) begin
        to_at = k;
        break;
      end
    end
    chk("timeout_cycle", to_at, 16);
    clr_log.delete();
    repeat (3) cycle();
    chk("post_timeout_clear", clr_log.size(), 1);
    if (clr_log.size() > 0) chk("post_timeout_src", clr_log[0], 0);
    v[0] = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ds_frame_arbiter.md
DS_FRAME_ARBITER -- requirements
Module: ds_frame_arbiter

Interface
REQ-001 The block SHALL have parameter in_width, default 240, meaning pixels per line.
REQ-002 The block SHALL have parameter in_height, default 480, meaning lines per frame.
REQ-003 The block SHALL have parameter timeout_cycles, default 1024, meaning the watchdog limit in idle grant cycles.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s0_data / s0_valid / s0_ready  input / input / output  8 / 1 / 1  stream 0 (left camera).
REQ-007 s1_data / s1_valid / s1_ready  input / input / output  8 / 1 / 1  stream 1 (right camera).
REQ-008 m_data / m_valid / m_ready  output / output / input  8 / 1 / 1  shared stream to the downsampler.
REQ-009 m_src  output  1  index of the granted stream.
REQ-010 ds_clear  output  1  one-cycle pulse that clears the downsampler col/phase counters.
REQ-011 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.
REQ-012 timeout_err  output  1  one-cycle pulse on watchdog abort; present only with DS_ARB_TIMEOUT_EN.

Function
REQ-013 The FSM SHALL have states IDLE, CLEAR, GRANT.
REQ-014 IDLE: when any sN_valid=1, the FSM SHALL select the source and go to CLEAR; s0_ready, s1_ready and m_valid SHALL be 0.
REQ-015 Source selection SHALL be round-robin at frame granularity: prefer the stream not served last; a lone requester wins; after reset, stream 0 is preferred.
REQ-016 CLEAR SHALL last exactly 1 cycle: ds_clear=1, no transfer, next state GRANT.
REQ-017 GRANT SHALL pass data combinationally with zero latency: m_data=sSEL_data, m_valid=sSEL_valid, sSEL_ready=m_ready; the non-selected ready SHALL be 0.
REQ-018 A pixel SHALL be accepted when m_valid and m_ready are both 1; the pixel counter SHALL use width $clog2(in_width*in_height) and increment per accepted pixel.
REQ-019 When the counter reaches in_width*in_height-1 and a pixel is accepted, the block SHALL pulse frame_done in the same cycle, zero the counter, record the last-served stream and enter IDLE.
REQ-020 m_src SHALL update only on entry to CLEAR and hold through GRANT.
REQ-021 A non-selected stream's valid SHALL never affect the counter or outputs mid-frame.
REQ-022 If both streams request in IDLE simultaneously, the non-last-served stream SHALL win; the other wins the next IDLE decision.
REQ-023 Backpressure (m_ready=0) SHALL stall the counter and SHALL never cause loss or duplication.

Reset
REQ-024 On reset the block SHALL enter IDLE, zero the counter, set m_src=0, set last-served=1, and drive ds_clear, frame_done, timeout_err, m_valid, s0_ready and s1_ready to 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame without a frame_done pulse and resume at IDLE on the next cycle.

Configuration
REQ-026 With macro DS_ARB_TIMEOUT_EN defined, GRANT SHALL count consecutive cycles with sSEL_valid=0; on reaching timeout_cycles, the block SHALL pulse timeout_err, zero the pixel counter, mark the stream served and return to IDLE; the watchdog count SHALL reset on any valid cycle.
REQ-027 Without DS_ARB_TIMEOUT_EN, the watchdog and the timeout_err port SHALL be absent, and GRANT SHALL wait indefinitely.

Verification
REQ-028 Use in_width=4, in_height=2 for directed tests.
- REQ-029 Only s0 streams 8 pixels with m_ready=1 -> ds_clear one cycle before the first transfer, m_src=0, frame_done coincides with the 8th transfer, then IDLE.
- REQ-030 Both valid from reset -> s0 frame, then s1 frame, then s0 frame; s1_ready is 0 throughout the s0 frames.
- REQ-031 m_ready toggles every cycle during a frame -> exactly 8 transfers, data order preserved, frame_done on the last one.
- REQ-032 Reset asserted after 3 pixels -> no frame_done pulse; the next frame starts with ds_clear and a counter of 0.
- REQ-033 With DS_ARB_TIMEOUT_EN and timeout_cycles=16, s1 stops after 5 pixels -> timeout_err asserts on the 16th idle cycle, then s0 is granted.
